inst_prefetch_queue: RTL and testbench
======================================

// Module: inst_prefetch_queue
// PURPOSE
//  Parametrised instruction prefetch unit between instruction memory and the decode stage.
//  Runs PC generation ahead of decode and issues pipelined fetch requests with valid/ready.
//  Buffers in-order responses in a DEPTH-entry queue.
//  On a taken branch/jump redirect, flushes the queue and discards in-flight responses.
// PARAMETERS
//  XLEN       32  address/PC width
//  DEPTH      4   queue entries; power of 2, >=2
//  MAX_OUTST  2   max fetch requests in flight; 1..DEPTH
//  RESET_PC   0   first fetch address after reset
// PORTS
//  clk             in   1              single clock; all state updates on falling edge
//  reset           in   1              asynchronous, active-low
//  redirect_valid  in   1              taken branch/jump from MEM stage
//  redirect_pc     in   XLEN           redirect target
//  imem_req_valid  out  1              fetch request valid
//  imem_req_ready  in   1              memory accepts request
//  imem_addr       out  XLEN           fetch address
//  imem_rsp_valid  in   1              in-order response valid (always accepted)
//  imem_rsp_data   in   32             instruction word
//  ifid_valid      out  1              queue head valid
//  ifid_ready      in   1              decode consumes head (low = stall)
//  ifid_pc         out  XLEN           PC of head
//  ifid_inst       out  32             head instruction
//  occupancy       out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  Reset (reset=0, async):
//   - fetch_pc=RESET_PC; queue empty; outst=0; drop=0; state=S_BOOT.
//   - Outputs: imem_req_valid=0, imem_addr=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_inst=32'h00000013, occupancy=0.
//  FSM:
//   - S_BOOT: one cycle -> S_RUN.
//   - S_RUN: normal operation; on redirect with in-flight responses to drop -> S_DRAIN.
//   - S_DRAIN: no requests issued; each rsp decrements drop; drop==0 -> S_RUN.
//  Request rule:
//   - imem_req_valid = S_RUN & !redirect_valid & (outst < MAX_OUTST) & (occupancy + outst < DEPTH).
//   - imem_addr = fetch_pc.
//   - On req_valid & req_ready: fetch_pc += 4; outst++ (pc pushed to a pc-tag FIFO of MAX_OUTST entries).
//  Response:
//   - With drop==0: the word and its tagged pc are pushed to the queue tail; outst--.
//   - With drop>0: the word is discarded; drop--; outst--.
//   - Response with outst==0 is ignored.
//  Dequeue:
//   - ifid_valid = occupancy!=0; ifid_pc/ifid_inst come from the head.
//   - When the queue is empty: ifid_pc=0, ifid_inst=NOP (0x13).
//   - ifid_valid & ifid_ready pops the head.
//   - Push and pop in the same cycle leave occupancy unchanged.
//  Redirect (highest priority):
//   - Queue cleared, pop ignored, fetch_pc=redirect_pc.
//   - drop = outst minus any response arriving that cycle; that response is discarded.
//   - Next state = drop!=0 ? S_DRAIN : S_RUN.
//   - Redirect in S_DRAIN updates fetch_pc and stays in S_DRAIN.
//   - Redirect in S_BOOT overrides RESET_PC.
//  Latency:
//   - Response at edge N -> ifid_valid at N+1; no bypass.
//   - Redirect at edge N with outst=0 -> request at N+1.
//   - PC arithmetic wraps modulo 2^XLEN.
//   - Full queue: no request issued; push can never occur while full.
//  Reset mid-operation: all state cleared immediately; responses still in flight after release are ignored (outst=0).
// CONFIGURATION
//  PREFETCH_PERF_EN defined:
//   - Adds outputs perf_stall[31:0] (cycles with ifid_ready & !ifid_valid).
//   - Adds perf_flushed[31:0] (entries cleared plus responses dropped by redirects).
//   - Both are saturating and reset to 0.
//  Not defined: ports and counters absent; no other behaviour change.
// STRUCTURE
//  Shared header cpu/fetch_defs.vh:
//   - FSM state encodings S_BOOT/S_RUN/S_DRAIN.
//   - NOP_INST=32'h00000013.
//   - PC increment constant 4.
//  Sub-module fetch_fifo #(WIDTH,DEPTH):
//   - Pointer-based circular buffer with push/pop/clear, count, head data.
//   - Used for the instruction queue (WIDTH=XLEN+32) and the pc-tag FIFO.
// TESTING
//  1. Reset release, mem ready 1-cycle latency, ifid_ready=1 -> ifid_pc 0,4,8,... each cycle after fill; inst words match.
//  2. ifid_ready=0 for 10 cycles, DEPTH=4 -> occupancy stops at 4; imem_req_valid low; no lost or duplicated pc.
//  3. Two requests in flight, redirect_pc=0x100 -> both responses dropped, S_DRAIN held; first ifid_pc=0x100.
//  4. Redirect in the same cycle as a response and a pop -> queue empty next cycle; no request issued that cycle.
//  5. Redirect to 0xFFFFFFFC -> next fetch addresses 0xFFFFFFFC, 0x00000000.
//  6. reset asserted mid-stream with a later stray response -> outputs at reset values; stray rsp ignored; PREFETCH_PERF_EN counters read 0.

Source files
------------

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: FSM state
// encodings, the NOP word presented when the queue is empty, and the
// sequential fetch stride.
package inst_prefetch_queue_pkg;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/inst_prefetch_queue_fetch_fifo.sv
// Pointer-based circular buffer with push/pop/clear, an occupancy count
// and a combinational head. Used both as the instruction queue and as the
// pc-tag FIFO that pairs in-order responses with their request address.
// DEPTH need not be a power of two; pointers wrap explicitly.
module inst_prefetch_queue_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and count bookkeeping; clear wins over push/pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the array is deliberately not reset; count gates whether the head
  // is meaningful, so stale contents are never observed.
  always_ff @(negedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch unit: runs the fetch PC ahead of decode, keeps up to
// MAX_OUTST pipelined requests in flight, buffers in-order responses in a
// DEPTH-entry queue and flushes on redirect, discarding stale responses.
// All state updates on the falling clock edge; reset is async active-low.
// Optional build macro PREFETCH_PERF_EN adds saturating stall/flush counters.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      MAX_OUTST = 2,
  parameter logic [XLEN-1:0]  RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  output logic                   ifid_valid,
  input  logic                   ifid_ready,
  output logic [XLEN-1:0]        ifid_pc,
  output logic [31:0]            ifid_inst,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]            perf_stall,
  output logic [31:0]            perf_flushed
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTST) + 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [1:0]       state, state_next;
  logic [XLEN-1:0]  fetch_pc;
  logic [OW-1:0]    drop, drop_next;
  logic [OW-1:0]    outst;
  logic [XLEN-1:0]  tag_head;
  logic [CW-1:0]    q_count;
  logic [XLEN+31:0] q_head;
  logic [SW-1:0]    pending;
  logic             req_fire, rsp_acc, q_push, q_pop;

  // A response only counts when something is actually in flight.
  assign rsp_acc  = imem_rsp_valid && (outst != '0);
  assign req_fire = imem_req_valid && imem_req_ready;
  assign q_push   = rsp_acc && (drop == '0) && !redirect_valid;
  assign q_pop    = ifid_valid && ifid_ready && !redirect_valid;

  // Queue slots already committed: buffered entries plus in-flight fetches.
  assign pending  = SW'(q_count) + SW'(outst);

  assign imem_req_valid = (state == S_RUN) && !redirect_valid &&
                          (outst < OW'(MAX_OUTST)) && (pending < SW'(DEPTH));
  assign imem_addr      = fetch_pc;

  assign ifid_valid = (q_count != '0);
  assign ifid_pc    = ifid_valid ? q_head[XLEN+31:32] : '0;
  assign ifid_inst  = ifid_valid ? q_head[31:0] : NOP_INST;
  assign occupancy  = q_count;

  // Drop budget: on redirect every response still in flight becomes stale.
  // NOTE: each always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    drop_next = drop;
    if (redirect_valid)              drop_next = outst - OW'(rsp_acc);
    else if (rsp_acc && drop != '0)  drop_next = drop - 1'b1;
  end

  // FSM next state: boot lasts one cycle, drain holds until stale rsps drain.
  always_comb begin
    state_next = state;
    case (state)
      S_BOOT:  state_next = S_RUN;
      S_RUN:   state_next = (redirect_valid && drop_next != '0) ? S_DRAIN : S_RUN;
      S_DRAIN: state_next = (!redirect_valid && drop_next == '0) ? S_RUN : S_DRAIN;
      default: state_next = S_BOOT;
    endcase
  end

  // FSM, drop counter and fetch PC registers; redirect overrides increment.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_BOOT;
      drop     <= '0;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      if (redirect_valid) fetch_pc <= redirect_pc;
      else if (req_fire)  fetch_pc <= fetch_pc + XLEN'(PC_INC);
    end
  end

  // Request addresses waiting for their response; its count is outst.
  inst_prefetch_queue_fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_acc),
    .clear     (1'b0),
    .count     (outst),
    .head      (tag_head)
  );

  // Instruction queue holding {pc, word}; redirect flushes it.
  inst_prefetch_queue_fetch_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({tag_head, imem_rsp_data}),
    .pop       (q_pop),
    .clear     (redirect_valid),
    .count     (q_count),
    .head      (q_head)
  );

`ifdef PREFETCH_PERF_EN
  logic [32:0] flush_inc;
  logic [32:0] flush_sum;

  assign flush_inc = (redirect_valid ? 33'(q_count) : 33'd0) +
                     33'(rsp_acc && (redirect_valid || drop != '0));
  assign flush_sum = {1'b0, perf_flushed} + flush_inc;

  // Saturating decode-starvation and flush-loss counters.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall   <= '0;
      perf_flushed <= '0;
    end else begin
      if (ifid_ready && !ifid_valid && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
      perf_flushed <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue. A behavioural in-order
// memory with random latency serves fetches; a stream model tracks the
// expected fetch address and the expected next decoded PC.
module tb_inst_prefetch_queue;

  localparam int XLEN      = 32;
  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ifid_valid, ifid_ready;
  logic [31:0] ifid_pc, ifid_inst;
  logic [2:0]  occupancy;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_stall, perf_flushed;
`endif

  inst_prefetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .ifid_valid(ifid_valid), .ifid_ready(ifid_ready),
    .ifid_pc(ifid_pc), .ifid_inst(ifid_inst),
    .occupancy(occupancy)
`ifdef PREFETCH_PERF_EN
    , .perf_stall(perf_stall), .perf_flushed(perf_flushed)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; int due; } req_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pop_cnt  = 0;
  int lat_min = 1, lat_max = 1, rsp_pct = 100, rdy_pct = 100, pop_pct = 100;
  logic        force_redir = 1'b0;
  logic [31:0] force_pc    = '0;
  logic [31:0] exp_fetch, exp_pop, last_pop_pc;
  req_t        inflight[$];
  logic [31:0] acc_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_0F1E;
  endfunction

  // One clock cycle: drive inputs after the rising edge, observe the
  // handshakes that the DUT will commit on the following falling edge.
  task automatic step();
    req_t r;
    int   in_flight_now;
    @(posedge clk);
    in_flight_now = inflight.size();
    if (inflight.size() != 0 && inflight[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(inflight[0].addr);
      void'(inflight.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    ifid_ready     = ($urandom_range(99) < pop_pct);
    redirect_valid = force_redir;
    redirect_pc    = force_pc;
    force_redir    = 1'b0;
    #1;
    check("occ_bound", occupancy <= DEPTH, 1);
    check("req_rule", imem_req_valid &&
          (in_flight_now >= MAX_OUTST || int'(occupancy) + in_flight_now >= DEPTH), 0);
    if (!ifid_valid) begin
      check("idle_pc", ifid_pc, 0);
      check("idle_inst", ifid_inst, NOP);
    end
    if (redirect_valid) begin
      check("redir_noreq", imem_req_valid, 0);
      exp_fetch = redirect_pc;
      exp_pop   = redirect_pc;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_addr, exp_fetch);
        r.addr = imem_addr;
        r.due  = cyc + $urandom_range(lat_max, lat_min);
        inflight.push_back(r);
        acc_log.push_back(imem_addr);
        exp_fetch = exp_fetch + 32'd4;
        check("outst_bound", inflight.size() <= MAX_OUTST, 1);
      end
      if (ifid_valid && ifid_ready) begin
        check("pop_pc", ifid_pc, exp_pop);
        check("pop_inst", ifid_inst, word_of(exp_pop));
        last_pop_pc = ifid_pc;
        pop_cnt++;
        exp_pop = exp_pop + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int rsp, input int rdy, input int pop);
    lat_min = lmin; lat_max = lmax; rsp_pct = rsp; rdy_pct = rdy; pop_pct = pop;
  endtask

  initial begin
    int p0;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    ifid_ready     = 1'b0;
    exp_fetch      = RESET_PC;
    exp_pop        = RESET_PC;
    last_pop_pc    = '1;

    // Reset state.
    #2;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_ifid_valid", ifid_valid, 0);
    check("rst_ifid_pc", ifid_pc, 0);
    check("rst_ifid_inst", ifid_inst, NOP);
    check("rst_occ", occupancy, 0);
`ifdef PREFETCH_PERF_EN
    check("rst_perf_stall", perf_stall, 0);
    check("rst_perf_flushed", perf_flushed, 0);
`endif
    @(posedge clk);
    reset = 1'b1;

    // 1: one-cycle memory, decode always ready -> one instruction per cycle.
    set_knobs(1, 1, 100, 100, 100);
    for (int i = 0; i < 20 && !ifid_valid; i++) step();
    check("t1_fill", ifid_valid, 1);
    for (int i = 0; i < 12; i++) begin
      step();
      check("t1_stream", ifid_valid, 1);
    end

    // 2: decode stalled -> queue fills to DEPTH and fetch stops.
    set_knobs(1, 1, 100, 100, 0);
    repeat (10) step();
    check("t2_occ_full", occupancy, DEPTH);
    check("t2_no_req", imem_req_valid, 0);
    set_knobs(1, 1, 100, 100, 100);
    repeat (6) step();

    // 3: redirect with two fetches in flight -> both dropped.
    set_knobs(4, 4, 100, 100, 100);
    for (int i = 0; i < 60 && !(inflight.size() == 2 && inflight[0].due > cyc); i++) step();
    check("t3_setup", inflight.size() == 2 && inflight[0].due > cyc, 1);
    force_redir = 1'b1;
    force_pc    = 32'h100;
    step();
    for (int i = 0; i < 20 && inflight.size() != 0; i++) begin
      step();
      check("t3_drain_noreq", imem_req_valid, 0);
      check("t3_drain_empty", occupancy, 0);
    end
    check("t3_drained", inflight.size(), 0);
    p0 = pop_cnt;
    for (int i = 0; i < 30 && pop_cnt == p0; i++) step();
    check("t3_first_pc", last_pop_pc, 32'h100);

    // 4: redirect coinciding with a response and a pop.
    set_knobs(1, 1, 100, 100, 100);
    repeat (12) step();
    force_redir = 1'b1;
    force_pc    = 32'h2000;
    step();
    check("t4_setup", {imem_rsp_valid, ifid_valid & ifid_ready}, 2'b11);
    @(negedge clk);
    #1;
    check("t4_occ", occupancy, 0);
    check("t4_ifid_valid", ifid_valid, 0);
    redirect_valid = 1'b0;
    #1;
    check("t4_req_next", imem_req_valid, 1);
    check("t4_addr_next", imem_addr, 32'h2000);

    // 5: PC wraps modulo 2^32.
    repeat (4) step();
    force_redir = 1'b1;
    force_pc    = 32'hFFFF_FFFC;
    step();
    acc_log.delete();
    for (int i = 0; i < 30 && acc_log.size() < 2; i++) step();
    check("t5_wait", acc_log.size() >= 2, 1);
    if (acc_log.size() >= 2) begin
      check("t5_addr0", acc_log[0], 32'hFFFF_FFFC);
      check("t5_addr1", acc_log[1], 32'h0000_0000);
    end

    // Randomised traffic with random redirects.
    p0 = pop_cnt;
    for (int blk = 0; blk < 15; blk++) begin
      set_knobs(1, $urandom_range(4, 1), $urandom_range(100, 30),
                $urandom_range(100, 30), $urandom_range(100, 20));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(99) < 3) begin
          force_redir = 1'b1;
          force_pc    = $urandom() & 32'hFFFF_FFFC;
        end
        step();
      end
    end
    check("rand_progress", (pop_cnt - p0) >= 100, 1);

    // 6: reset mid-stream with a stray response around release.
    reset = 1'b0;
    #1;
    check("t6_req_valid", imem_req_valid, 0);
    check("t6_addr", imem_addr, RESET_PC);
    check("t6_ifid_valid", ifid_valid, 0);
    check("t6_ifid_pc", ifid_pc, 0);
    check("t6_ifid_inst", ifid_inst, NOP);
    check("t6_occ", occupancy, 0);
`ifdef PREFETCH_PERF_EN
    check("t6_perf_stall", perf_stall, 0);
    check("t6_perf_flushed", perf_flushed, 0);
`endif
    inflight.delete();
    exp_fetch      = RESET_PC;
    exp_pop        = RESET_PC;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    imem_req_ready = 1'b1;
    ifid_ready     = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("t6_stray_occ", occupancy, 0);
    check("t6_stray_valid", ifid_valid, 0);
    check("t6_req_after", imem_req_valid, 1);
    check("t6_addr_after", imem_addr, RESET_PC);
    imem_rsp_valid = 1'b0;
    set_knobs(1, 1, 100, 100, 100);
    p0 = pop_cnt;
    repeat (30) step();
    check("t6_flow", (pop_cnt - p0) >= 20, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
